// File: rtl/ws2812_rx_if.sv
// Decoded-output bundle of the WS2812 receiver: word/frame strobes and error status.
interface ws2812_rx_if;
   logic [23:0] data_out;
   logic        data_valid;
   logic        frame_end;
   logic [15:0] frame_pixels;
   logic        err;
   logic [7:0]  err_count;

   modport master (
      output data_out, data_valid, frame_end, frame_pixels, err, err_count
   );

   modport slave (
      input data_out, data_valid, frame_end, frame_pixels, err, err_count
   );
endinterface

// File: rtl/ws2812_rx.sv
// WS2812 single-wire decoder: measures high time per pulse, rebuilds 24-bit GRB words.
// Optional saturating error counter enabled by defining WS2812_RX_ERRCNT_EN.
module ws2812_rx #(
   parameter int unsigned BIT_THRESH_CYC = 30,
   parameter int unsigned MIN_HIGH_CYC   = 8,
   parameter int unsigned MAX_HIGH_CYC   = 60,
   parameter int unsigned LATCH_CYC      = 2500
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        din,
   ws2812_rx_if.master bus
);

   localparam int unsigned HCW = $clog2(MAX_HIGH_CYC + 2);
   localparam int unsigned LCW = $clog2(LATCH_CYC + 1);

   localparam logic [HCW-1:0] THRESH_H = HCW'(BIT_THRESH_CYC);
   localparam logic [HCW-1:0] MIN_H    = HCW'(MIN_HIGH_CYC);
   localparam logic [HCW-1:0] MAX_H    = HCW'(MAX_HIGH_CYC);
   localparam logic [HCW-1:0] SAT_H    = HCW'(MAX_HIGH_CYC + 1);
   localparam logic [LCW-1:0] LATCH_L  = LCW'(LATCH_CYC);

   localparam logic [1:0] ST_WAIT_LATCH = 2'd0;
   localparam logic [1:0] ST_IDLE       = 2'd1;
   localparam logic [1:0] ST_HIGH       = 2'd2;
   localparam logic [1:0] ST_LOW        = 2'd3;

   logic            sync1_q, s_din_q, prev_q;
   logic [1:0]      state_q, state_d;
   logic [HCW-1:0]  high_cnt_q, high_cnt_d;
   logic [LCW-1:0]  low_cnt_q, low_cnt_d;
   logic [4:0]      bit_cnt_q, bit_cnt_d;
   logic [22:0]     shift_q, shift_d;
   logic [15:0]     pix_cnt_q, pix_cnt_d;
   logic [23:0]     data_out_q, data_out_d;
   logic            data_valid_q, data_valid_d;
   logic            frame_end_q, frame_end_d;
   logic [15:0]     frame_pixels_q, frame_pixels_d;
   logic            err_q, err_d;

   logic            rise, fall, bit_val;
   logic [LCW-1:0]  low_inc;
   logic [HCW-1:0]  high_inc;
   logic [15:0]     pix_inc;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b0;
         s_din_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= din;
         s_din_q <= sync1_q;
         prev_q  <= s_din_q;
      end
   end

   always_comb begin
      rise     = s_din_q & ~prev_q;
      fall     = ~s_din_q & prev_q;
      bit_val  = (high_cnt_q >= THRESH_H);
      low_inc  = (low_cnt_q == LATCH_L) ? low_cnt_q : low_cnt_q + 1'b1;
      high_inc = (high_cnt_q == SAT_H) ? high_cnt_q : high_cnt_q + 1'b1;
      pix_inc  = (pix_cnt_q == 16'hFFFF) ? pix_cnt_q : pix_cnt_q + 16'd1;

      state_d        = state_q;
      high_cnt_d     = high_cnt_q;
      low_cnt_d      = low_cnt_q;
      bit_cnt_d      = bit_cnt_q;
      shift_d        = shift_q;
      pix_cnt_d      = pix_cnt_q;
      data_out_d     = data_out_q;
      data_valid_d   = 1'b0;
      frame_end_d    = 1'b0;
      frame_pixels_d = frame_pixels_q;
      err_d          = 1'b0;

      case (state_q)
         ST_WAIT_LATCH: begin
            if (s_din_q) begin
               low_cnt_d = '0;
            end else if (low_inc == LATCH_L) begin
               low_cnt_d = '0;
               state_d   = ST_IDLE;
            end else begin
               low_cnt_d = low_inc;
            end
         end

         ST_IDLE: begin
            if (rise) begin
               high_cnt_d = HCW'(1);
               state_d    = ST_HIGH;
            end
         end

         ST_HIGH: begin
            // Overlong check precedes the falling edge so a pulse of MAX+1 is an error either way.
            if (high_cnt_q > MAX_H) begin
               err_d     = 1'b1;
               bit_cnt_d = '0;
               shift_d   = '0;
               low_cnt_d = '0;
               state_d   = ST_WAIT_LATCH;
            end else if (fall) begin
               low_cnt_d = '0;
               state_d   = ST_LOW;
               if (high_cnt_q < MIN_H) begin
                  err_d = 1'b1;
               end else if (bit_cnt_q == 5'd23) begin
                  data_out_d   = {shift_q, bit_val};
                  data_valid_d = 1'b1;
                  bit_cnt_d    = '0;
                  shift_d      = '0;
                  pix_cnt_d    = pix_inc;
               end else begin
                  shift_d   = {shift_q[21:0], bit_val};
                  bit_cnt_d = bit_cnt_q + 5'd1;
               end
            end else begin
               high_cnt_d = high_inc;
            end
         end

         default: begin
            if (rise) begin
               high_cnt_d = HCW'(1);
               state_d    = ST_HIGH;
            end else if (low_inc == LATCH_L) begin
               frame_end_d    = 1'b1;
               frame_pixels_d = pix_cnt_q;
               pix_cnt_d      = '0;
               low_cnt_d      = '0;
               state_d        = ST_IDLE;
               if (bit_cnt_q != 5'd0) begin
                  err_d     = 1'b1;
                  bit_cnt_d = '0;
                  shift_d   = '0;
               end
            end else begin
               low_cnt_d = low_inc;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= ST_WAIT_LATCH;
         high_cnt_q     <= '0;
         low_cnt_q      <= '0;
         bit_cnt_q      <= '0;
         shift_q        <= '0;
         pix_cnt_q      <= '0;
         data_out_q     <= '0;
         data_valid_q   <= 1'b0;
         frame_end_q    <= 1'b0;
         frame_pixels_q <= '0;
         err_q          <= 1'b0;
      end else begin
         state_q        <= state_d;
         high_cnt_q     <= high_cnt_d;
         low_cnt_q      <= low_cnt_d;
         bit_cnt_q      <= bit_cnt_d;
         shift_q        <= shift_d;
         pix_cnt_q      <= pix_cnt_d;
         data_out_q     <= data_out_d;
         data_valid_q   <= data_valid_d;
         frame_end_q    <= frame_end_d;
         frame_pixels_q <= frame_pixels_d;
         err_q          <= err_d;
      end
   end

`ifdef WS2812_RX_ERRCNT_EN
   logic [7:0] err_count_q, err_count_d;

   always_comb begin
      err_count_d = err_count_q;
      if (err_d && err_count_q != 8'hFF) begin
         err_count_d = err_count_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         err_count_q <= '0;
      end else begin
         err_count_q <= err_count_d;
      end
   end

   assign bus.err_count = err_count_q;
`else
   assign bus.err_count = '0;
`endif

   assign bus.data_out     = data_out_q;
   assign bus.data_valid   = data_valid_q;
   assign bus.frame_end    = frame_end_q;
   assign bus.frame_pixels = frame_pixels_q;
   assign bus.err          = err_q;

endmodule

// File: tb/tb_ws2812_rx.sv
// Directed bench for ws2812_rx: encodes WS2812 bit timings on din and checks decoded strobes.
module tb_ws2812_rx;

   logic clk = 1'b0;
   logic reset;
   logic din;

   ws2812_rx_if bus ();

   ws2812_rx #(
      .BIT_THRESH_CYC (30),
      .MIN_HIGH_CYC   (8),
      .MAX_HIGH_CYC   (60),
      .LATCH_CYC      (2500)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .din   (din),
      .bus   (bus)
   );

   always #10 clk = ~clk;

   int unsigned vectors     = 0;
   int unsigned miscompares = 0;

   int unsigned dv_n, fe_n, err_n, fe_err_n, dv_err_n;
   logic [23:0] words [0:7];
   logic [15:0] last_fp;

`ifdef WS2812_RX_ERRCNT_EN
   localparam logic [7:0] EXP_ERRCNT = 8'd255;
`else
   localparam logic [7:0] EXP_ERRCNT = 8'd0;
`endif

   // Strobe monitor samples 1 time unit after the active edge.
   always @(posedge clk) begin
      #1;
      if (bus.data_valid) begin
         if (dv_n < 8) words[dv_n] = bus.data_out;
         dv_n++;
      end
      if (bus.frame_end) begin
         last_fp = bus.frame_pixels;
         fe_n++;
      end
      if (bus.err) err_n++;
      if (bus.err && bus.frame_end) fe_err_n++;
      if (bus.err && bus.data_valid) dv_err_n++;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_mon();
      dv_n = 0; fe_n = 0; err_n = 0; fe_err_n = 0;
      last_fp = 16'hDEAD;
   endtask

   task automatic hold(input logic v, input int unsigned n);
      din = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b);
      if (b) begin
         hold(1'b1, 40); hold(1'b0, 25);
      end else begin
         hold(1'b1, 20); hold(1'b0, 45);
      end
   endtask

   task automatic glitch();
      hold(1'b1, 4); hold(1'b0, 10);
   endtask

   // Sends bits [23:stop] of w, MSB first; a glitch follows bit index glitch_after (-1: none).
   task automatic send_bits(input logic [23:0] w, input int stop, input int glitch_after);
      for (int i = 23; i >= stop; i--) begin
         send_bit(w[i]);
         if (i == glitch_after) glitch();
      end
   endtask

   task automatic send_word(input logic [23:0] w);
      send_bits(w, 0, -1);
   endtask

   initial begin
      dv_err_n = 0;
      clear_mon();
      din   = 1'b0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("rst_data_out",     32'(bus.data_out),     32'h0);
      check_eq("rst_data_valid",   32'(bus.data_valid),   32'h0);
      check_eq("rst_frame_end",    32'(bus.frame_end),    32'h0);
      check_eq("rst_frame_pixels", 32'(bus.frame_pixels), 32'h0);
      check_eq("rst_err",          32'(bus.err),          32'h0);
      check_eq("rst_err_count",    32'(bus.err_count),    32'h0);
      reset = 1'b0;

      // Single word
      hold(1'b0, 2600);
      clear_mon();
      send_word(24'hA53C0F);
      hold(1'b0, 2600);
      check_eq("t1_dv_n",  dv_n,              32'd1);
      check_eq("t1_word",  32'(words[0]),     32'hA53C0F);
      check_eq("t1_fe_n",  fe_n,              32'd1);
      check_eq("t1_fp",    32'(last_fp),      32'd1);
      check_eq("t1_err_n", err_n,             32'd0);

      // Three back-to-back words
      clear_mon();
      send_word(24'hFF0000);
      send_word(24'h00FF00);
      send_word(24'h0000FF);
      hold(1'b0, 2600);
      check_eq("t2_dv_n",  dv_n,          32'd3);
      check_eq("t2_w0",    32'(words[0]), 32'hFF0000);
      check_eq("t2_w1",    32'(words[1]), 32'h00FF00);
      check_eq("t2_w2",    32'(words[2]), 32'h0000FF);
      check_eq("t2_fp",    32'(last_fp),  32'd3);
      check_eq("t2_err_n", err_n,         32'd0);

      // Glitch after the sixth transmitted bit (index 18)
      clear_mon();
      send_bits(24'h123456, 0, 18);
      hold(1'b0, 2600);
      check_eq("t3_err_n", err_n,         32'd1);
      check_eq("t3_dv_n",  dv_n,          32'd1);
      check_eq("t3_word",  32'(words[0]), 32'h123456);
      check_eq("t3_fp",    32'(last_fp),  32'd1);

      // Partial word at latch
      clear_mon();
      send_bits(24'hFFF000, 12, -1);
      hold(1'b0, 2600);
      check_eq("t5_err_n",    err_n,        32'd1);
      check_eq("t5_fe_n",     fe_n,         32'd1);
      check_eq("t5_fe_err_n", fe_err_n,     32'd1);
      check_eq("t5_fp",       32'(last_fp), 32'd0);
      check_eq("t5_dv_n",     dv_n,         32'd0);

      // 300 glitches
      clear_mon();
      repeat (300) glitch();
      hold(1'b0, 2600);
      check_eq("t6_err_n",     err_n,              32'd300);
      check_eq("t6_dv_n",      dv_n,               32'd0);
      check_eq("t6_err_count", 32'(bus.err_count), 32'(EXP_ERRCNT));

      // Overlong pulse mid-word, rest of word ignored until a full latch gap
      clear_mon();
      send_bits(24'hABCDEF, 14, -1);
      hold(1'b1, 70);
      hold(1'b0, 45);
      send_bits(24'hABCDEF, 0, -1);
      hold(1'b0, 2600);
      check_eq("t4_err_n", err_n, 32'd1);
      check_eq("t4_dv_n",  dv_n,  32'd0);
      check_eq("t4_fe_n",  fe_n,  32'd0);
      clear_mon();
      send_word(24'h5A5A5A);
      hold(1'b0, 2600);
      check_eq("t4b_dv_n", dv_n,          32'd1);
      check_eq("t4b_word", 32'(words[0]), 32'h5A5A5A);
      check_eq("t4b_fp",   32'(last_fp),  32'd1);
      check_eq("t4b_err",  err_n,         32'd0);

      // Reset mid-word clears outputs and partial state
      clear_mon();
      send_bits(24'hC3C3C3, 14, -1);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check_eq("t7_data_out",     32'(bus.data_out),     32'h0);
      check_eq("t7_frame_pixels", 32'(bus.frame_pixels), 32'h0);
      check_eq("t7_err_count",    32'(bus.err_count),    32'h0);
      check_eq("t7_strobes",      32'({bus.data_valid, bus.frame_end, bus.err}), 32'h0);
      reset = 1'b0;
      hold(1'b0, 2600);
      clear_mon();
      send_word(24'h0F0F0F);
      hold(1'b0, 2600);
      check_eq("t7_dv_n",  dv_n,          32'd1);
      check_eq("t7_word",  32'(words[0]), 32'h0F0F0F);
      check_eq("t7_err_n", err_n,         32'd0);

      check_eq("dv_err_overlap", dv_err_n, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
